// File: rtl/fetch_prefetch_unit_if.sv
// rtl/fetch_prefetch_unit_if.sv - instruction memory and IF/ID handshake bundle for the fetch front end
interface fetch_prefetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    modport master (
        output imem_req, imem_addr, if_valid, if_instr, if_pc,
        input  imem_ack, imem_rdata, if_ready, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_instr, if_pc,
        output imem_ack, imem_rdata, if_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_prefetch_unit.sv
// rtl/fetch_prefetch_unit.sv - instruction prefetch: one-outstanding req/ack fetch into a small {pc,instr} FIFO
module fetch_prefetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOOP     = 32'h0000_0000
) (
    input  logic                  clock,
    input  logic                  reset_n,
    fetch_prefetch_unit_if.master bus
);
    localparam int          PW   = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DROP = 2'd2} state_t;

    state_t        state;
    logic [31:0]   pc_q    [DEPTH];
    logic [31:0]   instr_q [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;
    logic [PW:0]   count_next;
    logic [31:0]   addr;
    logic [31:0]   target;
    logic [31:0]   redirect_aligned;
    logic          req;
    logic          ack_seen;
    logic          push;
    logic          pop;
    logic          has_room;
    logic          head_valid;

    assign redirect_aligned = {bus.redirect_pc[31:2], 2'b00};
    assign head_valid       = (count != '0);
    assign ack_seen         = req & bus.imem_ack;
    // A redirect kills both the arriving word and the decode handoff this cycle.
    assign push             = ack_seen & (state == REQ) & ~bus.redirect;
    assign pop              = head_valid & bus.if_ready & ~bus.redirect;
    assign count_next       = count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    assign has_room         = (count_next < FULL);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            req    <= 1'b0;
            addr   <= RESET_PC;
            target <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (bus.redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
                count <= count_next;
            end

            case (state)
                IDLE: begin
                    if (bus.redirect) begin
                        addr  <= redirect_aligned;
                        state <= REQ;
                        req   <= 1'b1;
                    end else if (has_room) begin
                        state <= REQ;
                        req   <= 1'b1;
                    end
                end
                REQ: begin
                    if (ack_seen && bus.redirect) begin
                        addr <= redirect_aligned;
                    end else if (bus.redirect) begin
                        // Old request still in flight: remember where to go once it retires.
                        target <= redirect_aligned;
                        state  <= DROP;
                    end else if (ack_seen) begin
                        addr <= addr + 32'd4;
                        if (!has_room) begin
                            state <= IDLE;
                            req   <= 1'b0;
                        end
                    end
                end
                DROP: begin
                    if (bus.redirect) target <= redirect_aligned;
                    if (ack_seen) begin
                        addr  <= bus.redirect ? redirect_aligned : target;
                        state <= REQ;
                    end
                end
                default: begin
                    state <= IDLE;
                    req   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            pc_q[wr_ptr]    <= addr;
            instr_q[wr_ptr] <= bus.imem_rdata;
        end
    end

    assign bus.imem_req  = req;
    assign bus.imem_addr = addr;
    assign bus.if_valid  = head_valid;
    assign bus.if_instr  = head_valid ? instr_q[rd_ptr] : NOOP;
    assign bus.if_pc     = head_valid ? pc_q[rd_ptr] : 32'h0;
endmodule

// File: doc/fetch_prefetch_unit.md
# fetch_prefetch_unit

Instruction-fetch front end for the 5-stage MIPS pipeline. It fetches 32-bit instruction words from a multi-cycle instruction memory over a req/ack handshake and buffers them in a small FIFO. It presents them in order, with their PCs, to the IF/ID pipeline register. It honours decode stalls and flushes on branch/jump redirects, discarding any in-flight response.

## Interface
- DEPTH, 4, prefetch FIFO entries; power of two, ≥2
- RESET_PC, 32'h0000_0000, first fetch address after reset
- NOOP, 32'h0000_0000, word driven on if_instr when FIFO is empty
- Clock and reset: one clock; reset is asynchronous and active-low.
- clock  in  1  rising-edge clock, shared with the pipeline
- reset_n  in  1  asynchronous active-low reset
- imem_req  out  1  request valid; registered
- imem_addr  out  32  word address (bits [1:0] always 00); stable while imem_req=1
- imem_ack  in  1  response valid; only meaningful while imem_req=1
- imem_rdata  in  32  instruction word, valid with imem_ack
- if_ready  in  1  decode accepts this cycle (pipeline drives ~stall)
- redirect  in  1  taken branch/jump; flush and refetch
- redirect_pc  in  32  new fetch address; bits [1:0] ignored
- if_valid  out  1  FIFO non-empty
- if_instr  out  32  head instruction, or NOOP when empty
- if_pc  out  32  PC of head instruction, 0 when empty

## Operation
- FIFO: DEPTH entries of {pc, instr}; rd/wr pointers wrap mod DEPTH; count 0..DEPTH.
- push = accepted ack not dropped; pop = if_valid & if_ready & ~redirect; count_next = count + push − pop.
- State machine, driven by FSM state:
  - IDLE, imem_req=0. Go to REQ when count_next < DEPTH, or when redirect=1.
  - REQ, imem_req=1. Behaviour depends on the cycle:
    - No ack, no redirect: hold REQ and imem_addr.
    - Ack, no redirect: push {imem_addr, imem_rdata}. Set imem_addr += 4 (32-bit wrap). Stay in REQ if count_next < DEPTH, else go to IDLE.
    - Ack with redirect: drop the data. Set imem_addr = {redirect_pc[31:2],2'b00} and stay in REQ.
    - Redirect without ack: go to DROP. Latch target = redirect_pc; imem_addr is unchanged.
  - DROP, imem_req=1. Keep the old address and wait for ack.
    - A further redirect overwrites target.
    - On ack, discard the data, set imem_addr = target, and go to REQ.
- Redirect in any state flushes the FIFO: count=0 and pointers reset. A pop in the same cycle is suppressed. An ack push in the same cycle is suppressed.
- Redirect in IDLE: set imem_addr = redirect_pc aligned and go to REQ.
- Only one request is outstanding at a time; a new address is presented only after the ack of the previous one.
- Full FIFO (count=DEPTH): no request is issued. A pop moves the FSM to REQ on the next edge.
- Empty FIFO: if_valid=0, if_instr=NOOP, if_pc=0, so decode sees a bubble.
- Simultaneous push and pop with count=DEPTH−1: count is unchanged and fetching continues.

## Timing
- Reset (async, any time): FSM=IDLE, imem_req=0, imem_addr=RESET_PC, FIFO empty, if_valid=0, if_instr=NOOP, if_pc=0, target=0.
- An ack pending when reset asserts is ignored. The memory must abandon the request.
- First rising edge with reset_n=1: IDLE→REQ, so imem_req=1 in cycle 1.
- Latency: an ack at edge N makes the word visible on if_instr/if_valid after edge N (head output is combinational from FIFO storage).
- Throughput with a zero-wait memory (ack the same cycle as req): one instruction per cycle.
- Redirect at edge N: the FIFO is empty after N. If there is no outstanding request, imem_req=1 with the new address after N, and the first new instruction is available one cycle after its ack.
- Outputs if_valid/if_instr/if_pc change only on clock edges or reset.

## Test plan
- Reset then zero-wait memory returning instr=addr^32'hA5A5_0000, if_ready=1: imem_addr sequence 0,4,8,…; if_instr for PC 0 appears cycle 2; one instruction per cycle thereafter; if_pc matches.
- Stall: hold if_ready=0 for 10 cycles with a zero-wait memory and DEPTH=4: count reaches 4, imem_req drops to 0 with imem_addr=16; on release, instructions for PC 0,4,8,12 arrive in order and fetch of 16 resumes.
- Redirect while FIFO holds 3 entries and REQ has no ack (memory 3-cycle latency), redirect_pc=32'h0000_0103: if_valid=0 next cycle; the old response is dropped; the next imem_addr=32'h100; first delivered if_pc=32'h100.
- Redirect in the same cycle as ack and pop: no push, no pop, count=0; the next request address is the redirect target.
- Double redirect in DROP (0x200 then 0x300): after the old ack, imem_addr=0x300; 0x200 is never requested.
- Reset asserted mid-REQ with ack arriving the same cycle: all outputs return to reset values immediately; the word is not delivered; fetch restarts at RESET_PC.
